// File: rtl/md_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
//   WIDTH    operand width; hi/lo are WIDTH bits each, one iteration per bit
//   ITER_W   width of the iteration counter
//   OP_MUL / OP_DIV  operation select encodings
//   state_e  controller states
package md_pkg;

    localparam int WIDTH  = 32;
    localparam int ITER_W = $clog2(WIDTH + 1);

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_FINISH = 2'd2,
        S_DONE   = 2'd3
    } state_e;

endpackage

// File: rtl/mul_div_unit_if.sv
// Request/result bundle between the control unit and mul_div_unit.
//   start, op, a, b            request (driven by master)
//   busy, done, div_by_zero    status  (driven by slave)
//   hi, lo                     64-bit result (driven by slave)
interface mul_div_unit_if;
    import md_pkg::*;

    logic             start;
    logic             op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b,
        input  busy, done, div_by_zero, hi, lo
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, div_by_zero, hi, lo
    );

endinterface

// File: rtl/md_sign_fix.sv
// Combinational sign handling for signed division.
//   a_i, b_i          raw operands at accept -> a_mag_o, b_mag_o magnitudes
//   a_neg_i, b_neg_i  operand signs latched at accept
//   q_mag_i, r_mag_i  unsigned quotient/remainder from the iteration
//   quot_o, rem_o     signed quotient (truncated toward zero) and remainder
//                     (sign of the dividend)
module md_sign_fix
    import md_pkg::*;
(
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             a_neg_i,
    input  logic             b_neg_i,
    input  logic [WIDTH-1:0] q_mag_i,
    input  logic [WIDTH-1:0] r_mag_i,
    output logic [WIDTH-1:0] a_mag_o,
    output logic [WIDTH-1:0] b_mag_o,
    output logic [WIDTH-1:0] quot_o,
    output logic [WIDTH-1:0] rem_o
);

    // The most negative value maps onto itself, which is its correct
    // magnitude when read as unsigned.
    assign a_mag_o = a_i[WIDTH-1] ? -a_i : a_i;
    assign b_mag_o = b_i[WIDTH-1] ? -b_i : b_i;

    assign quot_o = (a_neg_i ^ b_neg_i) ? -q_mag_i : q_mag_i;
    assign rem_o  = a_neg_i ? -r_mag_i : r_mag_i;

endmodule

// File: rtl/mul_div_unit.sv
// Iterative signed WIDTHxWIDTH multiplier (radix-2 Booth) and WIDTH/WIDTH
// divider (restoring, on magnitudes) producing the Hi/Lo result.
//   clk   rising-edge clock
//   clr   asynchronous active-high reset; discards any in-flight operation
//   bus   request/result bundle (slave side), see mul_div_unit_if
// MUL: hi:lo = a*b.  DIV: lo = quotient, hi = remainder.
// The A/Q/M registers are shared by both operations.
module mul_div_unit
    import md_pkg::*;
(
    input  logic           clk,
    input  logic           clr,
    mul_div_unit_if.slave  bus
);

    state_e             state_q, state_d;
    logic [ITER_W-1:0]  cnt_q, cnt_d;
    logic [WIDTH:0]     acc_q, acc_d;     // A: one extra bit so a = -2^(WIDTH-1) is exact
    logic [WIDTH-1:0]   q_q, q_d;         // Q: multiplier / dividend / quotient
    logic               qm1_q, qm1_d;     // Booth q_-1
    logic [WIDTH:0]     m_q, m_d;         // M: multiplicand / divisor
    logic               op_q, op_d;
    logic               neg_a_q, neg_a_d;
    logic               neg_b_q, neg_b_d;
    logic               dz_pend_q, dz_pend_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               dz_q, dz_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic               accept;
    logic [WIDTH:0]     booth_sum;
    logic [WIDTH:0]     div_sh;
    logic [WIDTH:0]     div_diff;
    logic [WIDTH-1:0]   a_mag, b_mag, quot_fix, rem_fix;

    md_sign_fix u_sign_fix (
        .a_i     (bus.a),
        .b_i     (bus.b),
        .a_neg_i (neg_a_q),
        .b_neg_i (neg_b_q),
        .q_mag_i (q_q),
        .r_mag_i (acc_q[WIDTH-1:0]),
        .a_mag_o (a_mag),
        .b_mag_o (b_mag),
        .quot_o  (quot_fix),
        .rem_o   (rem_fix)
    );

    // Booth add/sub selected by {Q[0], q_-1}.
    always_comb begin
        unique case ({q_q[0], qm1_q})
            2'b01:   booth_sum = acc_q + m_q;
            2'b10:   booth_sum = acc_q - m_q;
            default: booth_sum = acc_q;
        endcase
    end

    // Restoring step: shift {A,Q} left, trial-subtract the divisor.
    assign div_sh   = {acc_q[WIDTH-1:0], q_q[WIDTH-1]};
    assign div_diff = div_sh - m_q;

    // NOTE: every variable gets its default before the case, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        q_d       = q_q;
        qm1_d     = qm1_q;
        m_d       = m_q;
        op_d      = op_q;
        neg_a_d   = neg_a_q;
        neg_b_d   = neg_b_q;
        dz_pend_d = dz_pend_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        dz_d      = dz_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        accept    = 1'b0;

        unique case (state_q)
            S_IDLE: accept = bus.start;

            S_RUN: begin
                if (op_q == OP_MUL) begin
                    // Arithmetic shift right of {A, Q, q_-1}.
                    acc_d = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
                    q_d   = {booth_sum[0], q_q[WIDTH-1:1]};
                    qm1_d = q_q[0];
                end else if (div_diff[WIDTH]) begin
                    acc_d = div_sh;
                    q_d   = {q_q[WIDTH-2:0], 1'b0};
                end else begin
                    acc_d = div_diff;
                    q_d   = {q_q[WIDTH-2:0], 1'b1};
                end
                cnt_d = cnt_q + ITER_W'(1);
                if (cnt_q == ITER_W'(WIDTH - 1)) state_d = S_FINISH;
            end

            S_FINISH: begin
                done_d  = 1'b1;
                state_d = S_DONE;
                if (dz_pend_q) begin
                    hi_d = q_q;               // holds the raw dividend
                    lo_d = '1;
                    dz_d = 1'b1;
                end else if (op_q == OP_MUL) begin
                    hi_d = acc_q[WIDTH-1:0];
                    lo_d = q_q;
                end else begin
                    hi_d = rem_fix;
                    lo_d = quot_fix;
                end
            end

            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
                // The DONE edge doubles as the first edge a new request can be taken.
                accept  = bus.start;
            end

            default: state_d = S_IDLE;
        endcase

        if (accept) begin
            busy_d    = 1'b1;
            dz_d      = 1'b0;
            op_d      = bus.op;
            cnt_d     = '0;
            acc_d     = '0;
            qm1_d     = 1'b0;
            dz_pend_d = 1'b0;
            neg_a_d   = bus.a[WIDTH-1];
            neg_b_d   = bus.b[WIDTH-1];
            if (bus.op == OP_DIV && bus.b == '0) begin
                // Divide by zero skips the iterations entirely.
                dz_pend_d = 1'b1;
                q_d       = bus.a;
                m_d       = '0;
                state_d   = S_FINISH;
            end else if (bus.op == OP_MUL) begin
                m_d     = {bus.a[WIDTH-1], bus.a};
                q_d     = bus.b;
                state_d = S_RUN;
            end else begin
                m_d     = {1'b0, b_mag};
                q_d     = a_mag;
                state_d = S_RUN;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of every other register.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            q_q       <= '0;
            qm1_q     <= 1'b0;
            m_q       <= '0;
            op_q      <= OP_MUL;
            neg_a_q   <= 1'b0;
            neg_b_q   <= 1'b0;
            dz_pend_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dz_q      <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            q_q       <= q_d;
            qm1_q     <= qm1_d;
            m_q       <= m_d;
            op_q      <= op_d;
            neg_a_q   <= neg_a_d;
            neg_b_q   <= neg_b_d;
            dz_pend_q <= dz_pend_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            dz_q      <= dz_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.div_by_zero = dz_q;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit.
module tb_mul_div_unit;
    import md_pkg::*;

    logic clk = 1'b0;
    logic clr = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    mul_div_unit_if bus ();

    mul_div_unit dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Wait (at negedges) for done; returns edges elapsed and busy samples seen.
    task automatic wait_done(inout int edges, inout int busy_cnt);
        while (!bus.done && edges < 100) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (bus.busy) busy_cnt++;
        end
    endtask

    // One complete operation issued from IDLE; operands are scrambled after
    // the accept edge to show they were latched.
    task automatic run_op(input string tag, input logic op,
                          input logic [31:0] a, input logic [31:0] b,
                          input int exp_lat, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo, input logic exp_dz);
        int edges;
        int busy_cnt;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(posedge clk);                        // E0
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = ~a;
        bus.b     = 32'h0000_1234;
        bus.op    = ~op;
        edges     = 0;
        busy_cnt  = bus.busy ? 1 : 0;
        check({tag, " accept_dz_clear"}, {63'd0, bus.div_by_zero}, 64'd0);
        wait_done(edges, busy_cnt);
        check({tag, " latency"}, 64'(edges), 64'(exp_lat));
        check({tag, " hi"}, {32'd0, bus.hi}, {32'd0, exp_hi});
        check({tag, " lo"}, {32'd0, bus.lo}, {32'd0, exp_lo});
        check({tag, " dz"}, {63'd0, bus.div_by_zero}, {63'd0, exp_dz});
        check({tag, " busy_cycles"}, 64'(busy_cnt), 64'(exp_lat + 1));
        @(posedge clk);
        @(negedge clk);
        check({tag, " idle_after"}, {62'd0, bus.busy, bus.done}, 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int edges;
        int busy_cnt;
        int done_cnt;

        bus.start = 1'b0;
        bus.op    = OP_MUL;
        bus.a     = '0;
        bus.b     = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset status", {61'd0, bus.busy, bus.done, bus.div_by_zero}, 64'd0);
        check("reset hilo", {bus.hi, bus.lo}, 64'd0);
        clr = 1'b0;

        // 1..3: MUL and DIV with hand-computed results
        run_op("mul 7*-3",    OP_MUL, 32'd7,         32'hFFFF_FFFD, 33, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        run_op("mul min*min", OP_MUL, 32'h8000_0000, 32'h8000_0000, 33, 32'h4000_0000, 32'h0000_0000, 1'b0);
        run_op("div -7/2",    OP_DIV, 32'hFFFF_FFF9, 32'd2,         33, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run_op("div 100/7",   OP_DIV, 32'd100,       32'd7,         33, 32'd2,         32'd14,        1'b0);

        // 4: divide by zero, then a MUL that clears the flag
        run_op("div 5/0",     OP_DIV, 32'd5,         32'd0,         1,  32'd5,         32'hFFFF_FFFF, 1'b1);
        run_op("mul 5*5",     OP_MUL, 32'd5,         32'd5,         33, 32'd0,         32'd25,        1'b0);

        // 5: start ignored while busy, then clr mid-operation
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = OP_MUL;
        bus.a     = 32'd3;
        bus.b     = 32'd4;
        @(posedge clk);                        // E0
        for (int e = 1; e <= 20; e++) begin
            @(negedge clk);
            bus.start = (e == 10);
            if (e == 10) begin
                bus.a = 32'd11;
                bus.b = 32'd13;
            end
            if (e == 20) begin
                check("clr busy_before", {63'd0, bus.busy}, 64'd1);
                clr = 1'b1;
            end
            @(posedge clk);
        end
        @(negedge clk);
        clr = 1'b0;
        check("clr status", {61'd0, bus.busy, bus.done, bus.div_by_zero}, 64'd0);
        check("clr hilo", {bus.hi, bus.lo}, 64'd0);
        done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done) done_cnt++;
        end
        check("clr no_done", 64'(done_cnt), 64'd0);
        run_op("div 9/3",     OP_DIV, 32'd9,         32'd3,         33, 32'd0,         32'd3,         1'b0);

        // 6: back-to-back with start held high
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = OP_MUL;
        bus.a     = 32'd2;
        bus.b     = 32'd3;
        @(posedge clk);                        // E0
        @(negedge clk);
        bus.op    = OP_DIV;
        bus.a     = 32'h8000_0000;
        bus.b     = 32'hFFFF_FFFF;
        edges     = 0;
        busy_cnt  = 0;
        wait_done(edges, busy_cnt);
        check("b2b mul latency", 64'(edges), 64'd33);
        check("b2b mul hilo", {bus.hi, bus.lo}, 64'd6);
        @(posedge clk);                        // E34: second accept
        @(negedge clk);
        bus.start = 1'b0;
        check("b2b accept", {62'd0, bus.busy, bus.done}, 64'd2);
        edges    = 0;
        busy_cnt = 0;
        wait_done(edges, busy_cnt);
        check("b2b div latency", 64'(edges), 64'd33);
        check("b2b div hilo", {bus.hi, bus.lo}, 64'h0000_0000_8000_0000);
        check("b2b div dz", {63'd0, bus.div_by_zero}, 64'd0);
        @(posedge clk);
        @(negedge clk);
        check("b2b idle_after", {62'd0, bus.busy, bus.done}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
